// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath width, requester indices and
// writeback arbiter state encoding.
package calc_pkg;

  localparam int unsigned CALC_DATA_W  = 64;
  localparam int unsigned CALC_NUM_SRC = 4;

  localparam logic [1:0] SRC_ADD = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd1;
  localparam logic [1:0] SRC_DIV = 2'd2;
  localparam logic [1:0] SRC_EXC = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux4_1_64.sv
// 4:1 mux for 64-bit calculator results.
module mux4_1_64 (
  input  logic [1:0]  selector,
  input  logic [63:0] data_in_00,
  input  logic [63:0] data_in_01,
  input  logic [63:0] data_in_10,
  input  logic [63:0] data_in_11,
  output logic [63:0] data_out
);

  always_comb begin
    data_out = data_in_00;
    case (selector)
      2'd0:    data_out = data_in_00;
      2'd1:    data_out = data_in_01;
      2'd2:    data_out = data_in_10;
      default: data_out = data_in_11;
    endcase
  end

endmodule

// File: rtl/calc_wb_arbiter.sv
// Round-robin arbiter for the shared result writeback path, with output register.
// Define CALC_ARB_PRIO3_EN to give the exception unit (source 3) strict priority.
module calc_wb_arbiter
  import calc_pkg::*;
#(
  parameter int unsigned NUM_SRC = CALC_NUM_SRC,
  parameter int unsigned DATA_W  = CALC_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [DATA_W-1:0]  data_in_00,
  input  logic [DATA_W-1:0]  data_in_01,
  input  logic [DATA_W-1:0]  data_in_10,
  input  logic [DATA_W-1:0]  data_in_11,
  output logic [NUM_SRC-1:0] ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_src,
  output logic [1:0]         sel
);

  // The datapath is a fixed 4:1 x 64-bit mux.
  if (NUM_SRC != 4 || DATA_W != 64) begin : g_cfg_check
    $error("calc_wb_arbiter supports only NUM_SRC=4, DATA_W=64");
  end

  arb_state_e        state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        ptr_nxt;
  logic [1:0]        win;
  logic              cap;
  logic              grant;
  logic [DATA_W-1:0] mux_out;
`ifdef CALC_ARB_PRIO3_EN
  logic [2:0]        idx3;
`else
  logic [1:0]        idx;
`endif

  // Winner selection, grant pulse and mux select.
  always_comb begin
    cap     = (state_q == ARB_IDLE) | ((state_q == ARB_HOLD) & out_ready);
    grant   = 1'b0;
    win     = ptr_q;
`ifdef CALC_ARB_PRIO3_EN
    idx3    = 3'd0;
    if (req[SRC_EXC]) begin
      grant = 1'b1;
      win   = SRC_EXC;
    end
    // Sources 0..2 rotate mod 3 below the exception unit.
    for (int i = 0; i < 3; i++) begin
      idx3 = {1'b0, ptr_q} + 3'(i);
      if (idx3 >= 3'd3) idx3 = idx3 - 3'd3;
      if (!grant && req[idx3[1:0]]) begin
        grant = 1'b1;
        win   = idx3[1:0];
      end
    end
    if (win == SRC_EXC)      ptr_nxt = ptr_q;
    else if (win == SRC_DIV) ptr_nxt = SRC_ADD;
    else                     ptr_nxt = win + 2'd1;
`else
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!grant && req[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
    ptr_nxt = win + 2'd1;
`endif
    ack = '0;
    sel = rst_n ? ptr_q : 2'd0;
    if (rst_n && cap && grant) begin
      ack[win] = 1'b1;
      sel      = win;
    end
  end

  mux4_1_64 u_mux (
    .selector   (sel),
    .data_in_00 (data_in_00),
    .data_in_01 (data_in_01),
    .data_in_10 (data_in_10),
    .data_in_11 (data_in_11),
    .data_out   (mux_out)
  );

  // FSM, round-robin pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= SRC_ADD;
      out_data <= '0;
      out_src  <= SRC_ADD;
    end else if (cap) begin
      if (grant) begin
        state_q  <= ARB_HOLD;
        ptr_q    <= ptr_nxt;
        out_data <= mux_out;
        out_src  <= win;
      end else begin
        state_q  <= ARB_IDLE;
      end
    end
  end

  assign out_valid = (state_q == ARB_HOLD);

endmodule

// File: tb/tb_calc_wb_arbiter.sv
// Directed self-checking bench for calc_wb_arbiter: reset cases, a per-cycle
// vector table for rotation/backpressure/drain, and the priority-3 build option.
module tb_calc_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0001;
  logic [63:0] data_in_00 = 64'h11;
  logic [63:0] data_in_01 = 64'h22;
  logic [63:0] data_in_10 = 64'h33;
  logic [63:0] data_in_11 = 64'h44;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  out_src;
  logic [1:0]  sel;

  int n_tests = 0;
  int n_fail  = 0;

  calc_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in_00 (data_in_00),
    .data_in_01 (data_in_01),
    .data_in_10 (data_in_10),
    .data_in_11 (data_in_11),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .sel        (sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  ack;
    logic [1:0]  sel;
    logic        valid;
    logic        chk_data;
    logic [63:0] data;
    logic [1:0]  src;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    // Row i: inputs driven for cycle i; ack/sel are this cycle's, out_* reflect earlier edges.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1, 64'h00, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 64'h22, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 64'h33, 2'd2};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 64'h44, 2'd3};
    vecs[5]  = '{4'b0110, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[6]  = '{4'b0110, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[7]  = '{4'b0110, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[8]  = '{4'b0110, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[9]  = '{4'b0110, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[10] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[11] = '{4'b0100, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b1, 64'h22, 2'd1};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 64'h22, 2'd1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b1, 64'h33, 2'd2};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 64'h00, 2'd0};
    vecs[15] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 64'h00, 2'd0};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[17] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 64'h11, 2'd0};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b1, 64'h44, 2'd3};
    vecs[19] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 64'h00, 2'd0};

    // Held in reset with a pending request.
    #2;
    check("rst ack", 64'(ack), 64'h0);
    check("rst valid", 64'(out_valid), 64'h0);
    check("rst data", out_data, 64'h0);
    check("rst src", 64'(out_src), 64'h0);
    check("rst sel", 64'(sel), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel ack", 64'(ack), 64'h1);
    check("rel sel", 64'(sel), 64'h0);

    @(negedge clk);
    req = 4'b0000;
    out_ready = 1'b0;
    #1;
    check("first valid", 64'(out_valid), 64'h1);
    check("first data", out_data, 64'h11);
    check("first src", 64'(out_src), 64'h0);
    check("hold ack", 64'(ack), 64'h0);
    check("hold sel ptr1", 64'(sel), 64'h1);

    // Asynchronous reset between edges while holding a result.
    rst_n = 1'b0;
    #1;
    check("async valid", 64'(out_valid), 64'h0);
    check("async data", out_data, 64'h0);
    check("async src", 64'(out_src), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post-rst ptr", 64'(sel), 64'h0);
    check("post-rst ack", 64'(ack), 64'h0);

`ifndef CALC_ARB_PRIO3_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = vecs[i].req;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d ack", i), 64'(ack), 64'(vecs[i].ack));
      check($sformatf("v%0d sel", i), 64'(sel), 64'(vecs[i].sel));
      check($sformatf("v%0d valid", i), 64'(out_valid), 64'(vecs[i].valid));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d data", i), out_data, vecs[i].data);
        check($sformatf("v%0d src", i), 64'(out_src), 64'(vecs[i].src));
      end
    end
`else
    // Source 3 wins every beat; pointer stays at 0 so source 0 follows.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 4'b1001;
      out_ready = 1'b1;
      #1;
      check($sformatf("p3 beat%0d ack", i), 64'(ack), 64'h8);
      if (i > 0) check($sformatf("p3 beat%0d src", i), 64'(out_src), 64'h3);
    end
    @(negedge clk);
    req = 4'b0011;
    #1;
    check("p3 after ack", 64'(ack), 64'h1);
    check("p3 data", out_data, 64'h44);
    @(negedge clk);
    req = 4'b0000;
    #1;
    check("p3 src0 data", out_data, 64'h11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
